branch_predictor: RTL and testbench

- Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters.
- Used by the next-generation pipeline to predict branches/jumps in IF instead of flushing on every taken branch resolved in EX.
- IF performs a combinational lookup on the current PC.
- EX supplies one resolved-branch update per cycle.
- Provides saturating branch and mispredict statistics counters.

---
 rtl/bp_pkg.sv | 19 +
 rtl/bp_sat_counter.sv | 28 ++
 rtl/branch_predictor.sv | 131 +++++++++++++
 tb/tb_branch_predictor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor slice.
// Holds the 2-bit direction counter encoding, the counter values used at
// reset and on allocation, and a helper that derives the BTB index width.
package bp_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // A freshly allocated entry was just seen taken, so it starts weakly taken.
   localparam logic [1:0] CNT_ALLOC = WT;
   localparam logic [1:0] CNT_RESET = WNT;

   function automatic int bp_idx_w(input int entries);
      return $clog2(entries);
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter next-state logic.
// Ports:
//   cnt      - current counter value
//   taken    - resolved direction (1 counts up, 0 counts down)
//   cnt_next - next counter value, held at ST/SNT when saturated
module bp_sat_counter
   import bp_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       taken,
   output logic [1:0] cnt_next
);

   // Move one step toward the resolved direction, stopping at either end.
   always_comb begin
      cnt_next = cnt;
      if (taken) begin
         if (cnt != ST) begin
            cnt_next = cnt + 2'd1;
         end
      end else begin
         if (cnt != SNT) begin
            cnt_next = cnt - 2'd1;
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// IF looks up if_pc combinationally; EX writes back one resolved branch per
// cycle. Also keeps saturating counts of resolved branches and mispredicts.
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   flush_all                    - invalidate every entry at the next edge
//   if_pc                        - fetch PC to predict
//   pred_taken, pred_target      - prediction for if_pc
//   upd_valid, upd_pc, upd_taken,
//   upd_target, upd_mispredict   - resolved branch from EX
//   stat_clr                     - zero the statistics counters
//   stat_branches, stat_mispred  - statistics counters
module branch_predictor
   import bp_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 8,
   parameter int STAT_W  = 16
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_all,
   input  logic [XLEN-1:0]   if_pc,
   output logic              pred_taken,
   output logic [XLEN-1:0]   pred_target,
   input  logic              upd_valid,
   input  logic [XLEN-1:0]   upd_pc,
   input  logic              upd_taken,
   input  logic [XLEN-1:0]   upd_target,
   input  logic              upd_mispredict,
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispred
);

   localparam int IDX_W = bp_idx_w(ENTRIES);

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [XLEN-1:0]    target_q [ENTRIES];
   logic [1:0]         cnt_q    [ENTRIES];

   logic [IDX_W-1:0]   if_idx;
   logic [TAG_W-1:0]   if_tag;
   logic               if_hit;

   logic [IDX_W-1:0]   upd_idx;
   logic [TAG_W-1:0]   upd_tag;
   logic               upd_hit;
   logic [1:0]         cnt_next;

   logic               upd_pc_unused;

   // Only the index and tag fields of upd_pc take part in the update.
   assign upd_pc_unused = ^upd_pc;

   assign if_idx  = if_pc[IDX_W+1:2];
   assign if_tag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

   // Lookup reads only registered state, so an update in the same cycle is
   // not visible until the following cycle.
   always_comb begin
      if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      pred_taken  = if_hit && cnt_q[if_idx][1];
      pred_target = if_pc + XLEN'(4);
      if (pred_taken) begin
         pred_target = target_q[if_idx];
      end
   end

   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   // A single counter step on the update path serves every entry, since at
   // most one entry is written per cycle.
   bp_sat_counter u_sat_counter (
      .cnt      (cnt_q[upd_idx]),
      .taken    (upd_taken),
      .cnt_next (cnt_next)
   );

   // BTB state. flush_all drops every valid bit and suppresses the update
   // for that cycle; counters and targets are kept. A miss that resolves
   // taken replaces whatever lived in that slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            cnt_q[i]    <= CNT_RESET;
         end
      end else if (flush_all) begin
         valid_q <= '0;
      end else if (upd_valid) begin
         if (upd_hit) begin
            cnt_q[upd_idx] <= cnt_next;
            if (upd_taken) begin
               target_q[upd_idx] <= upd_target;
            end
         end else if (upd_taken) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
            cnt_q[upd_idx]    <= CNT_ALLOC;
         end
      end
   end

   // Statistics saturate at all-ones; a clear beats a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else if (stat_clr) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else if (upd_valid) begin
         if (stat_branches != '1) begin
            stat_branches <= stat_branches + STAT_W'(1);
         end
         if (upd_mispredict && (stat_mispred != '1)) begin
            stat_mispred <= stat_mispred + STAT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor. Directed vectors with hand-computed
// expectations are queued as they are issued; a monitor on the falling
// edge pops one expectation per cycle and compares it with the outputs.
// A second instance with STAT_W=4 shares the inputs to cover saturation.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_all;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_mispredict;
   logic        stat_clr;
   logic [15:0] stat_branches;
   logic [15:0] stat_mispred;

   logic        pred_taken4;
   logic [31:0] pred_target4;
   logic [3:0]  stat_branches4;
   logic [3:0]  stat_mispred4;

   typedef struct packed {
      bit          cp;
      bit          et;
      logic [31:0] etgt;
      bit          cs;
      logic [15:0] eb;
      logic [15:0] em;
      bit          c4;
      logic [3:0]  eb4;
      logic [3:0]  em4;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    pass_count  = 0;
   int    total_count = 0;

   branch_predictor dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush_all      (flush_all),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_mispredict (upd_mispredict),
      .stat_clr       (stat_clr),
      .stat_branches  (stat_branches),
      .stat_mispred   (stat_mispred)
   );

   branch_predictor #(.STAT_W(4)) dut4 (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush_all      (flush_all),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken4),
      .pred_target    (pred_target4),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_mispredict (upd_mispredict),
      .stat_clr       (stat_clr),
      .stat_branches  (stat_branches4),
      .stat_mispred   (stat_mispred4)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the rising edge.
   task automatic applyStimulus(input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt,
                                input logic umis, input logic [31:0] ipc,
                                input logic fl, input logic sc);
      @(posedge clk);
      #1;
      upd_valid      = uv;
      upd_pc         = upc;
      upd_taken      = ut;
      upd_target     = utgt;
      upd_mispredict = umis;
      if_pc          = ipc;
      flush_all      = fl;
      stat_clr       = sc;
   endtask

   // Queue the expected outputs for the current cycle.
   task automatic checkOutput(input string name, input bit cp, input bit et,
                              input logic [31:0] etgt, input bit cs,
                              input int eb, input int em, input bit c4,
                              input int eb4, input int em4);
      exp_t e;
      e.cp   = cp;
      e.et   = et;
      e.etgt = etgt;
      e.cs   = cs;
      e.eb   = 16'(eb);
      e.em   = 16'(em);
      e.c4   = c4;
      e.eb4  = 4'(eb4);
      e.em4  = 4'(em4);
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   function automatic void compare(input string name, input string field,
                                   input logic [31:0] got,
                                   input logic [31:0] want);
      total_count++;
      if (got === want) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s %s: got 0x%0h expected 0x%0h",
                  name, field, got, want);
      end
   endfunction

   // Monitor: one expectation per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         if (e.cp) begin
            compare(n, "pred_taken", 32'(pred_taken), 32'(e.et));
            compare(n, "pred_target", pred_target, e.etgt);
         end
         if (e.cs) begin
            compare(n, "stat_branches", 32'(stat_branches), 32'(e.eb));
            compare(n, "stat_mispred", 32'(stat_mispred), 32'(e.em));
         end
         if (e.c4) begin
            compare(n, "stat_branches4", 32'(stat_branches4), 32'(e.eb4));
            compare(n, "stat_mispred4", 32'(stat_mispred4), 32'(e.em4));
         end
      end
   end

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n          = 1'b0;
      flush_all      = 1'b0;
      if_pc          = 32'h100;
      upd_valid      = 1'b0;
      upd_pc         = '0;
      upd_taken      = 1'b0;
      upd_target     = '0;
      upd_mispredict = 1'b0;
      stat_clr       = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", 1, 0, 32'h104, 1, 0, 0, 1, 0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Allocate 0x100 -> 0x80; the update cycle still sees the miss.
      applyStimulus(1, 32'h100, 1, 32'h80, 1, 32'h100, 0, 0);
      checkOutput("alloc_same_cycle", 1, 0, 32'h104, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 32'h100, 0, 0);
      checkOutput("alloc_hit", 1, 1, 32'h80, 1, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 32'h200, 0, 0);
      checkOutput("alias_miss", 1, 0, 32'h204, 0, 0, 0, 0, 0, 0);

      // Counter trajectory 10 -> 01 -> 10 -> 11 -> 11 -> 11 -> 10.
      applyStimulus(1, 32'h100, 0, 32'h0, 1, 32'h100, 0, 0);
      checkOutput("nt_pre", 1, 1, 32'h80, 1, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 32'h100, 0, 0);
      checkOutput("cnt_01", 1, 0, 32'h104, 1, 2, 2, 0, 0, 0);
      applyStimulus(1, 32'h100, 1, 32'h80, 0, 32'h100, 0, 0);
      checkOutput("t1_pre", 1, 0, 32'h104, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 32'h100, 1, 32'h80, 0, 32'h100, 0, 0);
      checkOutput("t2_pre", 1, 1, 32'h80, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 32'h100, 1, 32'h80, 0, 32'h100, 0, 0);
      applyStimulus(1, 32'h100, 1, 32'h80, 0, 32'h100, 0, 0);
      applyStimulus(1, 32'h100, 0, 32'h0, 0, 32'h100, 0, 0);
      checkOutput("st_pre_nt", 1, 1, 32'h80, 1, 6, 2, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 32'h100, 0, 0);
      checkOutput("cnt_10_target_kept", 1, 1, 32'h80, 1, 7, 2, 0, 0, 0);

      // flush_all beats a concurrent allocating update.
      applyStimulus(1, 32'h300, 1, 32'h500, 1, 32'h100, 1, 0);
      checkOutput("flush_pre", 1, 1, 32'h80, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 32'h100, 0, 0);
      checkOutput("flush_100", 1, 0, 32'h104, 1, 8, 3, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 32'h300, 0, 0);
      checkOutput("flush_300", 1, 0, 32'h304, 0, 0, 0, 0, 0, 0);

      // Statistics: clear, then three updates with one mispredict.
      applyStimulus(0, 0, 0, 0, 0, 32'h400, 0, 1);
      checkOutput("clr_pre", 0, 0, 0, 1, 8, 3, 1, 8, 3);
      applyStimulus(1, 32'h400, 0, 32'h0, 0, 32'h400, 0, 0);
      checkOutput("clr_done", 0, 0, 0, 1, 0, 0, 1, 0, 0);
      applyStimulus(1, 32'h400, 1, 32'h40, 1, 32'h400, 0, 0);
      applyStimulus(1, 32'h400, 0, 32'h0, 0, 32'h400, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 32'h400, 0, 0);
      checkOutput("stats_3_1", 1, 0, 32'h404, 1, 3, 1, 1, 3, 1);

      // Clear concurrent with an update; the BTB update still lands.
      applyStimulus(1, 32'h400, 1, 32'h44, 1, 32'h400, 0, 1);
      checkOutput("clr_upd_pre", 0, 0, 0, 1, 3, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 32'h400, 0, 0);
      checkOutput("clr_upd_post", 1, 1, 32'h44, 1, 0, 0, 1, 0, 0);

      // Twenty not-taken misses: the 4-bit counter stops at 15.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 32'h600, 0, 32'h0, 0, 32'h400, 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 32'h600, 0, 0);
      checkOutput("saturate", 1, 0, 32'h604, 1, 20, 0, 1, 15, 0);

      // Reset asserted mid-update takes effect before the next edge.
      applyStimulus(1, 32'h400, 1, 32'h44, 1, 32'h400, 0, 0);
      rst_n = 1'b0;
      checkOutput("async_reset", 1, 0, 32'h404, 1, 0, 0, 1, 0, 0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      upd_valid = 1'b0;
      checkOutput("post_reset", 1, 0, 32'h404, 1, 0, 0, 1, 0, 0);

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      if (exp_q.size() > 0) begin
         total_count++;
         $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule
